// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 pixel-stream driver.
// Cycle counts are rounded up so no pulse is ever shorter than requested.
package ws2812_pkg;

    typedef logic [23:0] grb_t;

    typedef enum logic {
        LATCH,
        BIT
    } state_t;

    function automatic int ns_to_cycles(input longint clock_hz, input longint ns);
        longint prod;
        prod = clock_hz * ns;
        return int'((prod + 999_999_999) / 1_000_000_000);
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Produces one WS2812 bit period: high for T0H or T1H cycles, then low.
// A start on the done cycle chains the next bit with no idle gap.
module ws2812_bit_encoder #(
    parameter int T0H  = 5,
    parameter int T1H  = 10,
    parameter int TBIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic value,
    output logic data_out,
    output logic done
);

    localparam int CW = $clog2(TBIT);
    localparam logic [CW-1:0] LAST = CW'(TBIT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] th;
    logic          busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            cnt      <= '0;
            th       <= '0;
            data_out <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            th       <= value ? CW'(T1H) : CW'(T0H);
            data_out <= 1'b1;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy     <= 1'b0;
                data_out <= 1'b0;
            end else begin
                cnt      <= cnt + 1'b1;
                data_out <= (cnt + 1'b1) < th;
            end
        end
    end

    assign done = busy && (cnt == LAST);

endmodule

// File: rtl/ws2812_driver.sv
// Continuously refreshes a WS2812 chain from an on/off vector, one colour
// for lit pixels, with a latch gap between frames.
module ws2812_driver import ws2812_pkg::*; #(
    parameter int   CLOCK_HZ       = 12_000_000,
    parameter int   NUMBER_OF_LEDS = 8,
    parameter grb_t COLOR_ON       = 24'h101010,
    parameter int   T0H_NS         = 400,
    parameter int   T1H_NS         = 800,
    parameter int   TBIT_NS        = 1250,
    parameter int   TRESET_NS      = 80_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUMBER_OF_LEDS-1:0] led_in,
    output logic                      data_out,
    output logic                      frame_start
);

    localparam int T0H    = ns_to_cycles(CLOCK_HZ, T0H_NS);
    localparam int T1H    = ns_to_cycles(CLOCK_HZ, T1H_NS);
    localparam int TBIT   = ns_to_cycles(CLOCK_HZ, TBIT_NS);
    localparam int TRESET = ns_to_cycles(CLOCK_HZ, TRESET_NS);

    localparam int GW = $clog2(TRESET + 1);
    localparam int PW = (NUMBER_OF_LEDS > 1) ? $clog2(NUMBER_OF_LEDS) : 1;
    localparam bit HAS_PRE = (TRESET >= 2);
    localparam logic [GW-1:0] GAP_END = GW'(TRESET - 1);
    localparam logic [GW-1:0] GAP_PRE = GW'(HAS_PRE ? TRESET - 2 : 0);
    localparam logic [PW-1:0] PIX_END = PW'(NUMBER_OF_LEDS - 1);

    if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && NUMBER_OF_LEDS >= 1))
    begin : g_cfg_err
        $error("ws2812_driver: invalid bit timing or LED count");
    end

    state_t                    state;
    logic [GW-1:0]             gap;
    logic [NUMBER_OF_LEDS-1:0] snap;
    logic [PW-1:0]             pix;
    logic [4:0]                bitn;
    logic                      last;

    grb_t color;
    logic cur_bit;
    logic fire;
    logic start;
    logic done;

    // frame_start is raised on the edge that lands the gap count on its
    // final value, so the pulse coincides with the exit cycle itself.
    always_comb begin
        color   = snap[pix] ? COLOR_ON : '0;
        cur_bit = color[bitn];
        fire    = (state == LATCH) && enable && !frame_start &&
                  ((gap == GAP_END) || (HAS_PRE && gap == GAP_PRE));
        start   = ((state == LATCH) && frame_start) ||
                  ((state == BIT) && done && !last);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LATCH;
            gap         <= '0;
            snap        <= '0;
            pix         <= '0;
            bitn        <= 5'd23;
            last        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fire;
            unique case (state)
                LATCH: begin
                    if (gap != GAP_END)
                        gap <= gap + 1'b1;
                    if (fire) begin
                        snap <= led_in;
                        pix  <= '0;
                        bitn <= 5'd23;
                        last <= 1'b0;
                    end
                    if (frame_start)
                        state <= BIT;
                end
                BIT: begin
                    if (done && last) begin
                        state <= LATCH;
                        gap   <= '0;
                    end
                end
                default: state <= LATCH;
            endcase
            // indices always point at the bit the encoder loads next
            if (start) begin
                if (bitn == 5'd0) begin
                    bitn <= 5'd23;
                    pix  <= pix + 1'b1;
                    last <= (pix == PIX_END);
                end else begin
                    bitn <= bitn - 1'b1;
                end
            end
        end
    end

    ws2812_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_enc (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (cur_bit),
        .data_out (data_out),
        .done     (done)
    );

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: a frame-level reference model checked every
// cycle, plus decoded-waveform checks on gap, pattern, snapshot and enable.
module tb_ws2812_driver;

    localparam int N     = 8;
    localparam int TB    = 15;
    localparam int TGAP  = 960;
    localparam int FLEN  = N * 24 * TB;
    localparam logic [23:0] COL_A = 24'hFF0000;
    localparam logic [23:0] COL_B = 24'h101010;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] led_in;
    logic         do_a, fs_a, do_b, fs_b;

    int n_tot = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ws2812_driver #(.COLOR_ON(COL_A)) dut_a (
        .clock(clk), .reset(reset), .enable(enable),
        .led_in(led_in), .data_out(do_a), .frame_start(fs_a)
    );

    ws2812_driver dut_b (
        .clock(clk), .reset(reset), .enable(enable),
        .led_in(led_in), .data_out(do_b), .frame_start(fs_b)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
                      name, got, exp, cyc);
    endtask

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Reference model: a frame is a flat run of FLEN cycles indexed by f;
    // the waveform at f follows from pixel, bit and phase arithmetic.
    int   ph = 0;
    int   g = 0;
    int   f = 0;
    bit   armed = 1'b0;
    logic [N-1:0] msnap = '0;

    function automatic logic wav(input logic [23:0] col, input int fi,
                                 input logic [N-1:0] s);
        int bp, pp, px, bn;
        logic v;
        bp = fi / TB;
        pp = fi % TB;
        px = bp / 24;
        bn = 23 - (bp % 24);
        v  = s[px] & col[bn];
        return pp < (v ? 10 : 5);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ph <= 0; g <= 0; f <= 0; armed <= 1'b1;
        end else if (ph == 0) begin
            if (g >= TGAP - 2 && enable) begin
                ph <= 1; g <= TGAP - 1; msnap <= led_in;
            end else if (g < TGAP - 1) begin
                g <= g + 1;
            end
        end else if (ph == 1) begin
            ph <= 2; f <= 0;
        end else if (f == FLEN - 1) begin
            ph <= 0; g <= 0;
        end else begin
            f <= f + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model", {fs_a, do_a, fs_b, do_b},
                {ph == 1, ph == 2 && wav(COL_A, f, msnap),
                 ph == 1, ph == 2 && wav(COL_B, f, msnap)});
        end
    end

    logic sa [FLEN];
    logic sb [FLEN];
    int   r_fs, r_hi, r_bad, r_l0, r_la, r_pre;
    logic [N-1:0] r_pix;

    task automatic grab(input bit wait_fs, input int chg_at,
                        input logic [N-1:0] chg_v, input int off_at);
        int ha, hb;
        bit ok;
        r_fs = -1; r_hi = -1; r_bad = 0; r_l0 = 0; r_la = 0; r_pre = 0;
        r_pix = '0;
        if (wait_fs) begin
            for (int n = 0; n < 6000; n++) begin
                @(negedge clk);
                if (fs_b) break;
                if (do_b) r_pre++;
            end
            chk("fs_seen", fs_b, 1);
            if (!fs_b) return;
        end
        r_fs = cyc;
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            if (i == chg_at) led_in = chg_v;
            if (i == off_at) enable = 1'b0;
            sa[i] = do_a;
            sb[i] = do_b;
            if (r_hi < 0 && do_b) r_hi = cyc;
        end
        for (int b = 0; b < N * 24; b++) begin
            ha = 0; hb = 0;
            for (int c = 0; c < TB; c++) begin
                ha += int'(sa[b*TB+c]);
                hb += int'(sb[b*TB+c]);
            end
            ok = (hb == 5 || hb == 10);
            for (int c = 0; c < TB; c++)
                if (sb[b*TB+c] != (c < hb)) ok = 1'b0;
            if (!ok) r_bad++;
            if (hb == 10) r_pix[b/24] = 1'b1;
            if (ha == 10) begin
                r_la++;
                if (b < 24) r_l0++;
            end
        end
    endtask

    initial begin
        logic [N-1:0] rv;
        int nfs, nhi;
        reset = 1'b1; enable = 1'b0; led_in = 8'h01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_do_b", do_b, 0);
        chk("rst_fs_b", fs_b, 0);
        chk("rst_do_a", do_a, 0);
        reset = 1'b0; enable = 1'b1;

        grab(1'b1, 0, 8'hA5, -1);
        chk("gap_fs_cyc", r_fs, 959);
        chk("first_hi", r_hi, 960);
        chk("gap_quiet", r_pre, 0);
        chk("f1_pix", r_pix, 8'h01);
        chk("a_pix0_long", r_l0, 8);
        chk("a_long_total", r_la, 8);
        chk("f1_shape", r_bad, 0);

        grab(1'b1, 100, 8'hFF, -1);
        chk("f2_fs_cyc", r_fs, 959 + 3840);
        chk("f2_pix", r_pix, 8'hA5);

        grab(1'b1, 750, 8'h00, -1);
        chk("f3_fs_cyc", r_fs, 959 + 2 * 3840);
        chk("f3_isolated", r_pix, 8'hFF);

        grab(1'b1, -1, 8'h00, 1000);
        chk("f4_pix", r_pix, 8'h00);
        chk("f4_shape", r_bad, 0);

        nfs = 0; nhi = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            led_in = 8'($urandom);
            nfs += int'(fs_b);
            nhi += int'(do_b);
        end
        chk("off_no_fs", nfs, 0);
        chk("off_no_hi", nhi, 0);

        rv = 8'($urandom);
        led_in = rv; enable = 1'b1;
        @(negedge clk);
        chk("en_fs", fs_b, 1);
        grab(1'b0, -1, 8'h00, -1);
        chk("en_hi_delay", r_hi - r_fs, 1);
        chk("en_pix", r_pix, rv);

        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            led_in = 8'($urandom);
            enable = ($urandom % 10) != 0;
        end

        enable = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (fs_b) break;
        end
        chk("pre_rst_fs", fs_b, 1);
        repeat (1 + 100 * TB) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_do", do_b, 0);
        chk("rst_mid_cyc", cyc, 0);
        reset = 1'b0;
        grab(1'b1, -1, 8'h00, -1);
        chk("rst_gap_fs", r_fs, 959);
        chk("rst_gap_hi", r_hi, 960);
        chk("rst_gap_quiet", r_pre, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
